// File: rtl/m_timer_device.sv
// m_timer_device: memory-mapped countdown timer that responds to the M-stage data bus.
// It holds CTRL/PRESET/COUNT and raises a maskable, level-sensitive interrupt toward CP0.
module m_timer_device #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inAddr,
    input  logic        inWE,
    input  logic [31:0] inWData,
    output logic [31:0] outRData,
    output logic        outIRQ
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    localparam logic [1:0] SEL_CTRL   = 2'd0;
    localparam logic [1:0] SEL_PRESET = 2'd1;
    localparam logic [1:0] SEL_COUNT  = 2'd2;
    localparam logic [1:0] MODE_AUTO  = 2'b01;

    // CTRL keeps only its implemented bits: [0] EN, [2:1] MODE, [3] IM.
    logic [3:0]  ctrl_q;
    logic [31:0] preset_q;
    logic [31:0] count_q;
    logic        irq_q;
    state_t      state_q;

    logic        hit;
    logic [1:0]  sel;
    logic        wr_ctrl;
    logic        wr_preset;
    logic        unused_addr_lsb;

    assign hit       = (inAddr[31:4] == BASE_ADDR[31:4]);
    assign sel       = inAddr[3:2];
    assign wr_ctrl   = hit && inWE && (sel == SEL_CTRL);
    assign wr_preset = hit && inWE && (sel == SEL_PRESET);

    // Byte offset within a word plays no role: only word stores are supported.
    assign unused_addr_lsb = ^inAddr[1:0];

    // Register file plus countdown sequencer. CPU writes are applied first so that
    // later FSM assignments take priority (irqFlag set beats a write clear), while
    // the hardware EN clear is skipped when the CPU writes CTRL in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q   <= 4'd0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
            irq_q    <= 1'b0;
            state_q  <= ST_IDLE;
        end else begin
            if (wr_ctrl) begin
                ctrl_q <= inWData[3:0];
            end
            if (wr_preset) begin
                preset_q <= inWData;
            end
            if (wr_ctrl || wr_preset) begin
                irq_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (ctrl_q[0]) begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    count_q <= preset_q;
                    state_q <= ST_CNT;
                end
                ST_CNT: begin
                    if (!ctrl_q[0]) begin
                        state_q <= ST_IDLE;
                    end else if (count_q == 32'd0) begin
                        state_q <= ST_INT;
                        irq_q   <= 1'b1;
                    end else begin
                        count_q <= count_q - 32'd1;
                    end
                end
                ST_INT: begin
                    if (ctrl_q[2:1] == MODE_AUTO) begin
                        // Auto-reload: the flag lives for exactly one cycle.
                        state_q <= ST_LOAD;
                        irq_q   <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                        if (!wr_ctrl) begin
                            ctrl_q[0] <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Combinational read port; misses and the reserved word read as zero.
    always_comb begin
        outRData = 32'd0;
        if (hit) begin
            case (sel)
                SEL_CTRL:   outRData = {28'd0, ctrl_q};
                SEL_PRESET: outRData = preset_q;
                SEL_COUNT:  outRData = count_q;
                default:    outRData = 32'd0;
            endcase
        end
    end

    assign outIRQ = irq_q & ctrl_q[3];

endmodule

// File: tb/tb_m_timer_device.sv
// tb_m_timer_device: directed literal checks plus randomized traffic compared every
// cycle against a timestamp-based behavioural model of the timer.
module tb_m_timer_device;

    localparam logic [31:0] BASE = 32'h0000_7F00;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] inAddr = 32'd0;
    logic        inWE = 1'b0;
    logic [31:0] inWData = 32'd0;
    logic [31:0] outRData;
    logic        outIRQ;

    int n_checks = 0;
    int n_err = 0;

    m_timer_device #(.BASE_ADDR(BASE)) dut (
        .clk     (clk),
        .reset   (reset),
        .inAddr  (inAddr),
        .inWE    (inWE),
        .inWData (inWData),
        .outRData(outRData),
        .outIRQ  (outIRQ)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // The timer is described by timestamps: the edge on which COUNT is loaded (m_t0),
    // the loaded value (m_L) and the edge on which the flag fires (t0 + 1 + L).
    logic [3:0]  m_ctrl = 4'd0;
    logic [31:0] m_preset = 32'd0;
    logic [31:0] m_count = 32'd0;
    logic [31:0] m_L = 32'd0;
    bit          m_irq = 1'b0;
    bit          m_on = 1'b0;
    longint      m_n = 0;
    longint      m_load_at = -1;
    longint      m_t0 = 0;
    longint      m_fire = -1;

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] r;
        r = 32'd0;
        if (a[31:4] == BASE[31:4]) begin
            case (a[3:2])
                2'd0: r = {28'd0, m_ctrl};
                2'd1: r = m_preset;
                2'd2: r = m_count;
                default: r = 32'd0;
            endcase
        end
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_L = 32'd0;
            m_irq = 1'b0; m_on = 1'b0; m_load_at = -1; m_fire = -1;
        end else begin
            logic [3:0] oc;
            logic [31:0] op;
            bit hitw, wc, wp;
            oc = m_ctrl;
            op = m_preset;
            hitw = (inAddr[31:4] == BASE[31:4]) && inWE;
            wc = hitw && (inAddr[3:2] == 2'd0);
            wp = hitw && (inAddr[3:2] == 2'd1);
            if (wc) m_ctrl = inWData[3:0];
            if (wp) m_preset = inWData;
            if (wc || wp) m_irq = 1'b0;

            if (!m_on) begin
                if (oc[0]) begin
                    m_on = 1'b1;
                    m_load_at = m_n + 1;
                end
            end else if (m_n == m_load_at) begin
                m_t0 = m_n;
                m_L = op;
                m_count = op;
                m_fire = m_n + 1 + longint'(op);
            end else if (m_n <= m_fire) begin
                if (!oc[0]) begin
                    m_on = 1'b0;
                end else if (m_n == m_fire) begin
                    m_irq = 1'b1;
                end else begin
                    m_count = m_L - 32'(m_n - m_t0);
                end
            end else begin
                if (oc[2:1] == 2'b01) begin
                    m_load_at = m_n + 1;
                    m_irq = 1'b0;
                end else begin
                    m_on = 1'b0;
                    if (!wc) m_ctrl[0] = 1'b0;
                end
            end
            m_n = m_n + 1;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle outside reset, the DUT must agree with the model.
    always @(negedge clk) begin
        if (!reset) begin
            chk("model_rdata", outRData, m_read(inAddr));
            chk("model_irq", {31'd0, outIRQ}, {31'd0, m_irq & m_ctrl[3]});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        inAddr = a;
        inWData = d;
        inWE = 1'b1;
        step();
        inWE = 1'b0;
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        inAddr = a;
        #1;
        chk(name, outRData, exp);
    endtask

    logic [31:0] miss_tab [5] = '{32'h0000_7F10, 32'h0000_7F14, 32'h0000_0000,
                                  32'h0000_7EFC, 32'hFFFF_7F00};

    initial begin
        // Reset then read
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        rd("rst_ctrl", 32'h7F00, 32'd0);
        rd("rst_preset", 32'h7F04, 32'd0);
        rd("rst_count", 32'h7F08, 32'd0);
        chk("rst_irq", {31'd0, outIRQ}, 32'd0);

        // One-shot: PRESET=5, interrupt 8 edges after the CTRL write
        wr(32'h7F04, 32'd5);
        wr(32'h7F00, 32'h9);
        inAddr = 32'h7F08;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("oneshot_irq_k%0d", k), {31'd0, outIRQ}, (k == 8) ? 32'd1 : 32'd0);
        end
        step();
        rd("oneshot_ctrl", 32'h7F00, 32'h8);
        rd("oneshot_count", 32'h7F08, 32'd0);
        chk("oneshot_irq_hold", {31'd0, outIRQ}, 32'd1);
        step();
        step();
        chk("oneshot_irq_hold2", {31'd0, outIRQ}, 32'd1);
        wr(32'h7F00, 32'h8);
        chk("oneshot_irq_cleared", {31'd0, outIRQ}, 32'd0);

        // Auto-reload: PRESET=2, pulse every 5 cycles, COUNT 2,1,0 between pulses
        wr(32'h7F04, 32'd2);
        wr(32'h7F00, 32'hB);
        inAddr = 32'h7F08;
        for (int k = 1; k <= 25; k++) begin
            int r;
            step();
            r = k % 5;
            chk($sformatf("auto_irq_k%0d", k), {31'd0, outIRQ}, (k >= 5 && r == 0) ? 32'd1 : 32'd0);
            chk($sformatf("auto_count_k%0d", k), outRData,
                (r == 2) ? 32'd2 : (r == 3) ? 32'd1 : 32'd0);
        end
        wr(32'h7F00, 32'h0);
        step();
        step();

        // Masked: flag sets internally, outIRQ stays 0
        wr(32'h7F04, 32'd3);
        wr(32'h7F00, 32'h1);
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("mask_irq", {31'd0, outIRQ}, 32'd0);
        end
        chk("mask_model_flag", {31'd0, m_irq}, 32'd1);

        // Disable during CNT freezes COUNT
        wr(32'h7F04, 32'd10);
        wr(32'h7F00, 32'h1);
        for (int k = 0; k < 4; k++) step();
        rd("dis_count_before", 32'h7F08, 32'd8);
        wr(32'h7F00, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            rd("dis_count_frozen", 32'h7F08, 32'd7);
        end

        // Address decode and read-only COUNT
        wr(32'h7F08, 32'h1234);
        rd("ro_count", 32'h7F08, 32'd7);
        wr(32'h7F10, 32'hFFFF);
        rd("miss_ctrl", 32'h7F00, 32'd0);
        rd("miss_preset", 32'h7F04, 32'd10);
        rd("miss_count", 32'h7F08, 32'd7);
        step();
        rd("reserved_rd", 32'h7F0C, 32'd0);
        rd("miss_rd", 32'h7F14, 32'd0);

        // Asynchronous reset mid-count
        wr(32'h7F04, 32'd100);
        wr(32'h7F00, 32'h9);
        for (int k = 0; k < 5; k++) step();
        rd("arst_count_before", 32'h7F08, 32'd97);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_count_now", outRData, 32'd0);
        chk("arst_irq_now", {31'd0, outIRQ}, 32'd0);
        step();
        step();
        reset = 1'b0;
        for (int k = 0; k < 120; k++) begin
            step();
            chk("arst_no_irq", {31'd0, outIRQ}, 32'd0);
        end

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int pick;
            logic [31:0] d;
            pick = int'($urandom_range(0, 9));
            case (pick)
                0, 1, 2: inAddr = 32'h7F00;
                3, 4:    inAddr = 32'h7F04;
                5, 6:    inAddr = 32'h7F08;
                7:       inAddr = 32'h7F0C;
                default: inAddr = miss_tab[$urandom_range(0, 4)];
            endcase
            d = $urandom();
            if (inAddr == 32'h7F00) begin
                d[0] = ($urandom_range(0, 9) < 8);
                if ($urandom_range(0, 1) == 1) d[2:1] = 2'b01;
            end else begin
                d = 32'($urandom_range(0, 6));
            end
            inWData = d;
            inWE = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #1;
                reset = 1'b1;
                #1;
                chk("rand_arst_rdata", outRData, 32'd0);
                reset = 1'b0;
            end
            step();
        end
        inWE = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
